// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, captures each digit once it has been stable,
// decodes it back to hex and emits complete display frames on a valid/ready interface.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_mask,
  output logic                    err,
  output logic                    overrun
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  localparam logic [1:0] StUnstable = 2'd0;
  localparam logic [1:0] StWait     = 2'd1;
  localparam logic [1:0] StCapture  = 2'd2;
  localparam logic [1:0] StHeld     = 2'd3;

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [1:0]              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [4*NUM_DIGITS-1:0] slot_data_q, slot_data_d;
  logic [NUM_DIGITS-1:0]   slot_mask_q, slot_mask_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_upd;
  logic                    out_valid_q, out_valid_d;
  logic [4*NUM_DIGITS-1:0] out_data_q, out_data_d;
  logic [NUM_DIGITS-1:0]   out_mask_q, out_mask_d;
  logic                    err_q, err_d;
  logic                    overrun_q, overrun_d;

  logic                    changed;
  logic                    do_capture;
  logic [6:0]              pat;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    an_none;
  logic                    an_multi;
  logic                    blank;
  logic                    frame_done;

  // Returns {hit, nibble}; nibble is zero when the pattern is not a hex glyph.
  function automatic logic [4:0] decode_hex(input logic [6:0] p);
    logic [4:0] r;
    r = 5'd0;
    case (p)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // The incoming sample is compared against the one already held, so the capture edge is the
  // (STABLE_CYCLES+1)th consecutive edge on which the bus carried the same value.
  assign changed = (seg_n != seg_q) || (an_n != an_q);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    do_capture = 1'b0;
    if (changed) begin
      state_d = StUnstable;
      cnt_d   = CntW'(1);
    end else begin
      case (state_q)
        StUnstable, StWait: begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CntMax) ? StCapture : StWait;
        end
        StCapture: begin
          do_capture = 1'b1;
          state_d    = StHeld;
        end
        StHeld:  state_d = StHeld;
        default: state_d = StUnstable;
      endcase
    end
  end

  assign pat      = ~seg_q;
  assign dec      = decode_hex(pat);
  assign an_act   = ~an_q;
  assign an_none  = (an_act == '0);
  assign an_multi = |(an_act & (an_act - NUM_DIGITS'(1)));
  assign blank    = (pat == 7'h00);

  always_comb begin
    slot_data_d = slot_data_q;
    slot_mask_d = slot_mask_q;
    seen_upd    = seen_q;
    err_d       = 1'b0;
    if (do_capture && !an_none) begin
      if (an_multi) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (an_act[i]) begin
            slot_data_d[4*i +: 4] = dec[3:0];
            slot_mask_d[i]        = dec[4];
            seen_upd[i]           = 1'b1;
          end
        end
        err_d = !dec[4] && !blank;
      end
    end
  end

  // seen_q is cleared whenever it would fill, so all-ones here only follows a fresh capture.
  assign frame_done = &seen_upd;
  assign seen_d     = frame_done ? '0 : seen_upd;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    overrun_d   = 1'b0;
    if (frame_done) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data_d;
      out_mask_d  = slot_mask_d;
      overrun_d   = out_valid_q && !out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '1;
      an_q        <= '1;
      state_q     <= StUnstable;
      cnt_q       <= '0;
      slot_data_q <= '0;
      slot_mask_q <= '0;
      seen_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      seg_q       <= seg_n;
      an_q        <= an_n;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_data_q <= slot_data_d;
      slot_mask_q <= slot_mask_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign err       = err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized bench for seg7_scan_decoder against a run-length based reference model.
module tb_seg7_scan_decoder;

  localparam int unsigned N = 4;
  localparam int unsigned S = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     seg_n;
  logic [N-1:0]   an_n;
  logic           out_ready;
  logic           out_valid;
  logic [4*N-1:0] out_data;
  logic [N-1:0]   out_mask;
  logic           err;
  logic           overrun;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS   (N),
    .STABLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_mask (out_mask),
    .err      (err),
    .overrun  (overrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned err_cnt  = 0;
  int unsigned ovr_cnt  = 0;

  logic [6:0] hex_codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a digit is captured on the edge where the bus value has been seen S+1 times.
  logic [6:0]     m_last_seg;
  logic [N-1:0]   m_last_an;
  int unsigned    m_run;
  logic [3:0]     m_nib  [N];
  logic           m_ok   [N];
  logic           m_seen [N];
  logic           m_valid;
  logic [4*N-1:0] m_data;
  logic [N-1:0]   m_mask;
  logic           m_err;
  logic           m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_seg = '1;
    m_last_an  = '1;
    m_run      = 0;
    for (int i = 0; i < N; i++) begin
      m_nib[i]  = 4'h0;
      m_ok[i]   = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_mask  = '0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [N-1:0] a, input logic r);
    int         low;
    int         idx;
    logic       hit;
    logic       all_seen;
    logic       done;
    logic [3:0] val;
    logic [6:0] p;
    m_err = 1'b0;
    m_ovr = 1'b0;
    done  = 1'b0;
    if (s == m_last_seg && a == m_last_an) begin
      m_run++;
    end else begin
      m_run      = 1;
      m_last_seg = s;
      m_last_an  = a;
    end
    if (m_run == S + 1) begin
      low = 0;
      idx = 0;
      for (int i = 0; i < N; i++) begin
        if (!a[i]) begin
          low++;
          idx = i;
        end
      end
      if (low > 1) begin
        m_err = 1'b1;
      end else if (low == 1) begin
        p   = ~s;
        hit = 1'b0;
        val = 4'h0;
        for (int c = 0; c < 16; c++) begin
          if (hex_codes[c] == p) begin
            hit = 1'b1;
            val = 4'(c);
          end
        end
        m_nib[idx]  = val;
        m_ok[idx]   = hit;
        m_seen[idx] = 1'b1;
        if (!hit && p != 7'h00) m_err = 1'b1;
        all_seen = 1'b1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all_seen = 1'b0;
        if (all_seen) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
        end
      end
    end
    if (done) begin
      m_ovr   = m_valid && !r;
      m_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_data[4*i +: 4] = m_nib[i];
        m_mask[i]        = m_ok[i];
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    logic [6:0]   s;
    logic [N-1:0] a;
    logic         r;
    s = seg_n;
    a = an_n;
    r = out_ready;
    @(posedge clk);
    model_edge(s, a, r);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_mask", 32'(out_mask), 32'(m_mask));
    check("err", 32'(err), 32'(m_err));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (err === 1'b1) err_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  endtask

  task automatic hold(input logic [N-1:0] a, input logic [6:0] p, input int cycles);
    an_n  = a;
    seg_n = ~p;
    repeat (cycles) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_mask"}, 32'(out_mask), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           rise;
    int           at;
    int           sel;
    int           cyc;
    logic [N-1:0] a_r;
    logic [6:0]   p_r;

    rst_n     = 1'b0;
    seg_n     = '1;
    an_n      = '1;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame: 3,1,F,0 on digits 0..3.
    err_cnt = 0;
    hold(4'b1110, 7'h4F, 10);
    hold(4'b1101, 7'h06, 10);
    hold(4'b1011, 7'h71, 10);
    an_n  = 4'b0111;
    seg_n = ~7'h3F;
    rise  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (out_valid === 1'b1 && rise == 0) rise = i;
    end
    check("frame1_rise_edge", 32'(rise), 32'd5);
    check("frame1_data", 32'(out_data), 32'h0F13);
    check("frame1_mask", 32'(out_mask), 32'hF);
    check("frame1_valid", 32'(out_valid), 32'd1);
    check("frame1_no_err", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    check("frame1_accept", 32'(out_valid), 32'd0);

    // Stability filter: S cycles is too short, S+1 captures on the last of them.
    err_cnt = 0;
    hold(4'b1110, 7'h01, 4);
    hold(4'b1111, 7'h00, 2);
    check("short_hold_no_capture", 32'(err_cnt), 32'd0);
    an_n  = 4'b1110;
    seg_n = ~7'h01;
    at    = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (err === 1'b1 && at == 0) at = i;
    end
    check("stable_capture_edge", 32'(at), 32'd5);

    // Illegal, blank and multi-enable patterns.
    err_cnt = 0;
    hold(4'b1110, 7'h5B, 6);
    hold(4'b1101, 7'h66, 6);
    hold(4'b1100, 7'h7F, 6);
    check("multi_enable_err", 32'(err_cnt), 32'd1);
    hold(4'b1011, 7'h01, 6);
    check("illegal_err_pulse", 32'(err_cnt), 32'd2);
    an_n  = 4'b0111;
    seg_n = ~7'h00;
    repeat (5) tick();
    check("blank_no_err", 32'(err_cnt), 32'd2);
    check("frame2_valid", 32'(out_valid), 32'd1);
    check("frame2_mask", 32'(out_mask), 32'h3);
    check("frame2_data", 32'(out_data), 32'h0042);
    tick();

    // Two frames with no consumer: the second overwrites the first.
    out_ready = 1'b0;
    ovr_cnt   = 0;
    hold(4'b1110, 7'h06, 6);
    hold(4'b1101, 7'h5B, 6);
    hold(4'b1011, 7'h4F, 6);
    hold(4'b0111, 7'h66, 6);
    check("frameA_data", 32'(out_data), 32'h4321);
    hold(4'b1110, 7'h6D, 6);
    hold(4'b1101, 7'h7D, 6);
    hold(4'b1011, 7'h07, 6);
    hold(4'b0111, 7'h7F, 6);
    check("overrun_once", 32'(ovr_cnt), 32'd1);
    check("frameB_valid", 32'(out_valid), 32'd1);
    check("frameB_data", 32'(out_data), 32'h8765);
    check("frameB_mask", 32'(out_mask), 32'hF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("frameB_accept", 32'(out_valid), 32'd0);

    // Asynchronous reset after two captures discards them.
    hold(4'b1110, 7'h77, 6);
    hold(4'b1101, 7'h7C, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("midreset_held");
    seg_n = '1;
    an_n  = '1;
    model_reset();
    rst_n = 1'b1;
    hold(4'b1011, 7'h79, 6);
    hold(4'b0111, 7'h71, 6);
    check("postreset_partial", 32'(out_valid), 32'd0);
    hold(4'b1110, 7'h39, 6);
    hold(4'b1101, 7'h5E, 6);
    check("postreset_valid", 32'(out_valid), 32'd1);
    check("postreset_data", 32'(out_data), 32'hFEDC);
    check("postreset_mask", 32'(out_mask), 32'hF);

    // Randomized segments with a random consumer.
    for (int k = 0; k < 250; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) p_r = hex_codes[$urandom_range(0, 15)];
      else if (sel < 7) p_r = 7'h00;
      else p_r = 7'($urandom);
      sel = int'($urandom_range(0, 9));
      a_r = '1;
      if (sel < 7) a_r[$urandom_range(0, N - 1)] = 1'b0;
      else if (sel > 7) a_r = N'($urandom);
      cyc   = int'($urandom_range(1, 8));
      an_n  = a_r;
      seg_n = ~p_r;
      for (int c = 0; c < cyc; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
